// File: rtl/pipe_reg_n.sv
// Elastic register pipeline of DEPTH valid/ready stages with bubble collapsing, stall and flush.
// Define PIPE_REG_N_SKID_EN to add a one-entry input skid that cuts the out_ready -> in_ready path.

module pipe_reg_n_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);
    // Data only moves with a valid word so q stays put while bubbles pass through.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (enable && load) begin
            valid <= up_valid;
            if (up_valid) data <= up_data;
        end
    end
endmodule

module pipe_reg_n #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            d,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            q,
    output logic [$clog2(DEPTH+2)-1:0]  occupancy
);
    localparam int OW = $clog2(DEPTH+2);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            open;
    logic [DEPTH-1:0][WIDTH-1:0] r;
    logic [DEPTH-1:0]            up_v;
    logic [DEPTH-1:0][WIDTH-1:0] up_r;
    logic                        in_fire;
    logic                        src_valid;
    logic [WIDTH-1:0]            src_data;

    // A stage is open unless it and every stage below it are full with the sink stalled.
    always_comb begin
        logic all_full;
        all_full = ~out_ready;
        open     = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            all_full = all_full & v[i];
            open[i]  = ~all_full;
        end
    end

`ifdef PIPE_REG_N_SKID_EN
    logic             sv;
    logic [WIDTH-1:0] sr;

    assign in_ready  = enable & ~sv & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign src_valid = sv | in_fire;
    assign src_data  = sv ? sr : d;

    // The skid only fills when stage 0 is blocked, and drains ahead of new input.
    always_ff @(posedge clock) begin
        if (reset) begin
            sv <= 1'b0;
            sr <= '0;
        end else if (flush) begin
            sv <= 1'b0;
        end else if (enable) begin
            if (open[0]) begin
                sv <= 1'b0;
            end else if (in_fire) begin
                sv <= 1'b1;
                sr <= d;
            end
        end
    end
`else
    assign in_ready  = enable & ~flush & open[0];
    assign in_fire   = in_valid & in_ready;
    assign src_valid = in_fire;
    assign src_data  = d;
`endif

    always_comb begin
        up_v[0] = src_valid;
        up_r[0] = src_data;
        for (int i = 1; i < DEPTH; i++) begin
            up_v[i] = v[i-1];
            up_r[i] = r[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            pipe_reg_n_stage #(.WIDTH(WIDTH)) u_stage (
                .clock    (clock),
                .reset    (reset),
                .enable   (enable),
                .flush    (flush),
                .load     (open[g]),
                .up_valid (up_v[g]),
                .up_data  (up_r[g]),
                .valid    (v[g]),
                .data     (r[g])
            );
        end
    endgenerate

    assign out_valid = v[DEPTH-1] & enable & ~flush;
    assign q         = r[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(v[i]);
`ifdef PIPE_REG_N_SKID_EN
        occupancy = occupancy + OW'(sv);
`endif
    end
endmodule

// File: tb/tb_pipe_reg_n.sv
// Bench for pipe_reg_n (WIDTH=32, DEPTH=3, default build): vector table, corner sequences,
// random traffic, and a queue scoreboard that follows every accepted and delivered word.
module tb_pipe_reg_n;
    localparam int W  = 32;
    localparam int D  = 3;
    localparam int OW = $clog2(D+2);

    logic          clock = 1'b0;
    logic          reset, enable, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  d, q;
    logic [OW-1:0] occupancy;

    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic         iv, ordy, en, fl;
        logic [W-1:0] dd;
        logic         ir, ov;
        logic [OW-1:0] occ;
    } vec_t;
    vec_t tbl[10];

    pipe_reg_n #(.WIDTH(W), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .occupancy(occupancy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic iv, input logic ordy, input logic en, input logic fl,
                         input logic [W-1:0] dd);
        in_valid = iv; out_ready = ordy; enable = en; flush = fl; d = dd;
    endtask

    task automatic do_reset;
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1;
        while (occupancy != 0 && n < 20) begin
            step;
            n++;
        end
        chk({name, "_drained"}, occupancy, 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    // Scoreboard: sample handshakes mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (mon_en) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_extra: got q=%08h with no word expected at %0t", q, $time);
                end else begin
                    chk("sb_q", q, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(d);
            if (reset || flush) sb.delete();
        end
    end

    initial begin
        logic [W-1:0]  w;
        logic [W-1:0]  q_f;
        logic [OW-1:0] occ_f;
        logic          en;

        // iv ordy en fl d | in_ready out_valid occupancy
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA1, 1'b1, 1'b0, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA2, 1'b1, 1'b0, 3'd1};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA3, 1'b1, 1'b0, 3'd2};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hA4, 1'b0, 1'b1, 3'd3};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hA4, 1'b1, 1'b1, 3'd3};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 3'd3};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 3'd3};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hEE, 1'b0, 1'b0, 3'd2};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD, 1'b0, 1'b0, 3'd2};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 3'd0};

        // Reset state, observed while reset is still held.
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        reset = 1'b1;
        step;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 1'b0;
        mon_en = 1'b1;

        // Table: bubble collapse, full, drain, stall freeze, flush at occupancy 2.
        do_reset;
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].iv, tbl[k].ordy, tbl[k].en, tbl[k].fl, tbl[k].dd);
            #1;
            chk($sformatf("tbl%0d_in_ready", k), in_ready, tbl[k].ir);
            chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].ov);
            chk($sformatf("tbl%0d_occ", k), occupancy, tbl[k].occ);
            step;
        end
        chk("tbl_sb_empty", sb.size(), 0);

        // Latency DEPTH and one word per cycle.
        do_reset;
        for (int t = 0; t < 13; t++) begin
            drive(t < 8, 1'b1, 1'b1, 1'b0, W'(t + 1));
            #1;
            chk($sformatf("lat%0d_in_ready", t), in_ready, 1);
            chk($sformatf("lat%0d_out_valid", t), out_valid, (t >= 3 && t <= 10));
            if (t >= 3 && t <= 10) chk($sformatf("lat%0d_q", t), q, W'(t - 2));
            step;
        end

        // Sink stalled for 6 cycles under continuous input.
        do_reset;
        w = 32'h100;
        for (int t = 0; t < 6; t++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, w);
            #1;
            if (in_ready) w++;
            step;
        end
        #1;
        chk("stall_occ", occupancy, D);
        chk("stall_in_ready", in_ready, 0);
        drain("stall");

        // Global stall mid-stream freezes everything.
        do_reset;
        w = 32'h200;
        occ_f = '0;
        q_f = '0;
        for (int t = 0; t < 14; t++) begin
            en = !(t >= 5 && t < 9);
            drive(1'b1, 1'b1, en, 1'b0, w);
            #1;
            if (t == 5) begin
                occ_f = occupancy;
                q_f = q;
            end
            if (!en) begin
                chk($sformatf("en%0d_in_ready", t), in_ready, 0);
                chk($sformatf("en%0d_out_valid", t), out_valid, 0);
            end
            if (t > 5 && !en) begin
                chk($sformatf("en%0d_occ_frozen", t), occupancy, occ_f);
                chk($sformatf("en%0d_q_frozen", t), q, q_f);
            end
            if (in_ready) w++;
            step;
        end
        drain("enable");

        // Reset mid-stream discards everything.
        do_reset;
        for (int t = 0; t < 5; t++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, W'(32'h300 + t));
            step;
        end
        reset = 1'b1;
        step;
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_q", q, 0);
        chk("mrst_occ", occupancy, 0);
        chk("mrst_in_ready", in_ready, 1);
        step;
        step;
        chk("mrst_sb_empty", sb.size(), 0);

        // Random traffic with stalls and occasional flushes.
        do_reset;
        w = 32'h1000;
        for (int t = 0; t < 300; t++) begin
            logic fl;
            en = ($urandom_range(0, 7) != 0);
            fl = ($urandom_range(0, 31) == 0);
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, en, fl, w);
            #1;
            chk("rnd_occ_vs_sb", occupancy, sb.size());
            if (!en || fl) begin
                chk("rnd_in_ready_gated", in_ready, 0);
                chk("rnd_out_valid_gated", out_valid, 0);
            end
            if (in_valid && in_ready) w++;
            step;
        end
        drain("rnd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_reg_n.md
PIPE_REG_N -- requirements
Module: pipe_reg_n

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 2: number of register stages, legal range 1..8.
REQ-003 Port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port enable, input, 1 bit: global stall; 0 freezes all state and blocks both handshakes.
REQ-006 Port flush, input, 1 bit: synchronous discard of all held words.
REQ-007 Port in_valid, input, 1 bit: producer offers d.
REQ-008 Port in_ready, output, 1 bit: block accepts d this cycle.
REQ-009 Port d, input, WIDTH bits: input payload.
REQ-010 Port out_valid, output, 1 bit: q holds a valid word.
REQ-011 Port out_ready, input, 1 bit: consumer takes q this cycle.
REQ-012 Port q, output, WIDTH bits: output payload, driven from the last stage register.
REQ-013 Port occupancy, output, clog2(DEPTH+2) bits: number of valid words held.

Function
REQ-014 Each stage i (0..DEPTH-1) has a valid bit v[i] and a data register r[i]; stage 0 is the input side, stage DEPTH-1 drives q.
REQ-015 out_valid = v[DEPTH-1] & enable; q = r[DEPTH-1].
REQ-016 Input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-017 Stage-open terms: open[DEPTH-1] = ~v[DEPTH-1] | out_ready; open[i] = ~v[i] | open[i+1] for i below DEPTH-1.
REQ-018 When enable=1 and a stage is open, the stage loads from its upstream neighbour; stage 0 loads from d (or from the skid entry, see Configuration).
REQ-019 Bubble collapsing: an empty stage always accepts, even when downstream stages are stalled.
REQ-020 Latency: a word accepted in cycle t into an empty pipeline is presented on q with out_valid=1 in cycle t+DEPTH.
REQ-021 Throughput: one word per cycle when out_ready=1 continuously.
REQ-022 Word order is preserved; no word is duplicated or dropped, except by flush or reset.
REQ-023 enable=0: in_ready=0, out_valid=0, and no v, r or skid state changes; state resumes unchanged when enable returns to 1.
REQ-024 flush=1 (regardless of enable): all valid bits, including skid, clear at the edge.
REQ-025 flush=1: in_ready=0 in the flush cycle, so no input transfer occurs.
REQ-026 flush=1: out_valid=0 in the flush cycle.
REQ-027 flush=1: data registers retain their values.
REQ-028 Simultaneous reset and flush: reset governs.
REQ-029 occupancy equals the popcount of all valid bits (plus skid valid when present), computed combinationally from registered state.
REQ-030 Full condition: with all stages valid and out_ready=0, in_ready=0 and occupancy=DEPTH (DEPTH+1 with skid).

Reset
REQ-031 reset=1 at a rising edge clears all v bits, the skid valid bit, all r registers and the skid register to 0.
REQ-032 Outputs during and after reset: out_valid=0, q=0, occupancy=0, in_ready=enable.
REQ-033 Reset asserted mid-stream discards all held words; none appears on q after reset.

Configuration
REQ-034 Macro PIPE_REG_N_SKID_EN compiles in a one-entry input skid buffer (skid valid bit sv, skid register sr).
REQ-035 With PIPE_REG_N_SKID_EN defined, in_ready = enable & ~sv & ~flush, with no combinational path from out_ready.
REQ-036 With PIPE_REG_N_SKID_EN defined, an accepted word is captured into sv/sr when stage 0 is not open.
REQ-037 With PIPE_REG_N_SKID_EN defined, the skid entry loads stage 0 with priority over d, and latency is unchanged when the skid is empty.
REQ-038 Without PIPE_REG_N_SKID_EN, in_ready = enable & ~flush & open[0] (combinational from out_ready), and no sv/sr state exists.

Verification
REQ-039 WIDTH=32, DEPTH=3, out_ready=1: after reset, stream 0x00000001..0x00000008 back-to-back -> q shows 0x00000001 three cycles after first accept, then one word per cycle in order.
REQ-040 Continuous input, out_ready=0 for 6 cycles -> occupancy reaches 3 (4 with skid), in_ready drops to 0, all words emerge in order after release with none lost.
REQ-041 One word in, out_ready=0 -> the next two offered words are still accepted (bubble collapse), occupancy=3.
REQ-042 flush with in_valid=1 and occupancy=2 -> next cycle out_valid=0, occupancy=0, and the word offered in the flush cycle never appears on q.
REQ-043 enable=0 for 4 cycles mid-stream -> in_ready=0, out_valid=0, state frozen, and the output sequence after enable=1 is identical to an unstalled run.
REQ-044 reset mid-stream with out_ready=1 -> next cycle out_valid=0, q=0x00000000, occupancy=0.
